// File: rtl/dma_pkg.sv
// dma_pkg
// Shared declarations for the DMA bus responder:
//   - hold_state_e : hold-acknowledge FSM state encoding
//   - DMA_MEM_AW_DEFAULT / DMA_BASE_ADDR_DEFAULT : default geometry of the
//     memory window (index width and first 16-bit address).
package dma_pkg;

  localparam int          DMA_MEM_AW_DEFAULT    = 8;
  localparam logic [15:0] DMA_BASE_ADDR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_CPU = 2'd1,
    ST_GRANT    = 2'd2,
    ST_RELEASE  = 2'd3
  } hold_state_e;

endpackage

// File: rtl/dma_bus_responder_if.sv
// dma_bus_responder_if
// Bus bundle between a DMA controller (master) and the memory responder
// (slave).
//   HRQ/HLDA         : hold request / hold acknowledge
//   CPU_BUSY         : host CPU bus cycle in progress
//   AEN, ADSTB       : DMA address enable, upper-address strobe
//   ADDR_U, ADDR_L   : address bits A7-A4 and A3-A0
//   MEMR_N, MEMW_N   : active-low memory read / write strobes
//   DB_IN            : data bus as sampled by the responder
//   DB_OUT, DB_OE    : read data and its drive enable
//   EOP_OUT_N        : end-of-process pull (1 = released)
//   ERR              : sticky protocol error
interface dma_bus_responder_if;
  logic       HRQ;
  logic       HLDA;
  logic       CPU_BUSY;
  logic       AEN;
  logic       ADSTB;
  logic [3:0] ADDR_U;
  logic [3:0] ADDR_L;
  logic       MEMR_N;
  logic       MEMW_N;
  logic [7:0] DB_IN;
  logic [7:0] DB_OUT;
  logic       DB_OE;
  logic       EOP_OUT_N;
  logic       ERR;

  modport master (
    output HRQ, CPU_BUSY, AEN, ADSTB, ADDR_U, ADDR_L, MEMR_N, MEMW_N, DB_IN,
    input  HLDA, DB_OUT, DB_OE, EOP_OUT_N, ERR
  );

  modport slave (
    input  HRQ, CPU_BUSY, AEN, ADSTB, ADDR_U, ADDR_L, MEMR_N, MEMW_N, DB_IN,
    output HLDA, DB_OUT, DB_OE, EOP_OUT_N, ERR
  );
endinterface

// File: rtl/dma_resp_mem.sv
// dma_resp_mem
// Byte-wide storage of 2**AW entries: synchronous write, registered read.
// The array itself is never reset; only the read-data register is cleared.
// Ports:
//   CLK, RESET : clock and synchronous active-high reset (read register only)
//   we_i       : write enable, wdata_i stored at addr_i on the rising edge
//   re_i       : read enable, mem[addr_i] captured into rdata_o
//   addr_i     : entry index
//   wdata_i    : write data
//   rdata_o    : registered read data
module dma_resp_mem #(
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [0:(2**AW)-1];
  logic [7:0] rdata_q;

  // Storage array write port
  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdata_q <= 8'h00;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dma_bus_responder.sv
// dma_bus_responder
// Memory-side responder for an 8237-style DMA bus. It grants the bus hold
// (HLDA) once the host CPU is idle, latches the upper address byte on ADSTB,
// and serves qualified reads/writes against a byte memory window starting at
// BASE_ADDR.
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   RESET : synchronous active-high reset
//   bus   : dma_bus_responder_if.slave (handshake, address, strobes, data)
// Configuration macro:
//   DMA_RESP_BOUNDS_EN : when defined, qualified accesses outside the window
//                        are suppressed and EOP_OUT_N pulses low for one
//                        cycle; otherwise addresses wrap within the window.
module dma_bus_responder
  import dma_pkg::*;
#(
  parameter int          MEM_AW    = DMA_MEM_AW_DEFAULT,
  parameter logic [15:0] BASE_ADDR = DMA_BASE_ADDR_DEFAULT
) (
  input logic                 CLK,
  input logic                 RESET,
  dma_bus_responder_if.slave  bus
);

  hold_state_e       state_q;
  logic              hlda_q;
  logic [7:0]        upper_q;
  logic              db_oe_q;
  logic              err_q;
  logic              eop_n_q;
  logic              memw_seen_q;   // qualified write strobe was low last cycle

  logic [15:0]       addr_s;
  logic [MEM_AW-1:0] mem_idx_s;
  logic              in_win_s;
  logic              qual_s;
  logic              rd_strb_s;
  logic              wr_strb_s;
  logic              conflict_s;
  logic              rd_go_s;
  logic              wr_go_s;
  logic [7:0]        rdata_s;

  assign addr_s    = {upper_q, bus.ADDR_U, bus.ADDR_L};
  // Truncation to the index width gives the wrap-around behaviour.
  assign mem_idx_s = MEM_AW'(addr_s - BASE_ADDR);

`ifdef DMA_RESP_BOUNDS_EN
  logic [16:0] offset_s;
  logic        acc_seen_q;
  logic        acc_s;
  // Addresses below BASE_ADDR borrow into bit 16 and so fail the compare.
  assign offset_s = {1'b0, addr_s} - {1'b0, BASE_ADDR};
  assign in_win_s = (offset_s < (17'd1 << MEM_AW));
  assign acc_s    = rd_strb_s | wr_strb_s;
`else
  assign in_win_s = 1'b1;
`endif

  // Accesses count only while the bus is held for DMA and AEN is high.
  assign qual_s     = hlda_q & bus.AEN;
  assign rd_strb_s  = qual_s & ~bus.MEMR_N;
  assign wr_strb_s  = qual_s & ~bus.MEMW_N;
  assign conflict_s = rd_strb_s & wr_strb_s;
  assign rd_go_s    = rd_strb_s & ~wr_strb_s & in_win_s;
  // Write only on the first qualified low cycle of a strobe.
  assign wr_go_s    = wr_strb_s & ~rd_strb_s & ~memw_seen_q & in_win_s;

  dma_resp_mem #(
    .AW (MEM_AW)
  ) u_mem (
    .CLK     (CLK),
    .RESET   (RESET),
    .we_i    (wr_go_s & ~RESET),
    .re_i    (rd_go_s & ~RESET),
    .addr_i  (mem_idx_s),
    .wdata_i (bus.DB_IN),
    .rdata_o (rdata_s)
  );

  // Hold FSM; HLDA is registered and high exactly while in GRANT
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      hlda_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.HRQ && !bus.CPU_BUSY) begin
            state_q <= ST_GRANT;
            hlda_q  <= 1'b1;
          end else if (bus.HRQ) begin
            state_q <= ST_WAIT_CPU;
            hlda_q  <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            hlda_q  <= 1'b0;
          end
        end
        ST_WAIT_CPU: begin
          // A withdrawn request wins over the CPU going idle.
          if (!bus.HRQ) begin
            state_q <= ST_IDLE;
            hlda_q  <= 1'b0;
          end else if (!bus.CPU_BUSY) begin
            state_q <= ST_GRANT;
            hlda_q  <= 1'b1;
          end else begin
            state_q <= ST_WAIT_CPU;
            hlda_q  <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (!bus.HRQ) begin
            state_q <= ST_RELEASE;
            hlda_q  <= 1'b0;
          end else begin
            state_q <= ST_GRANT;
            hlda_q  <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          hlda_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          hlda_q  <= 1'b0;
        end
      endcase
    end
  end

  // Address latch, read drive enable, error flag and strobe history
  always_ff @(posedge CLK) begin
    if (RESET) begin
      upper_q     <= 8'h00;
      db_oe_q     <= 1'b0;
      err_q       <= 1'b0;
      memw_seen_q <= 1'b0;
      eop_n_q     <= 1'b1;
`ifdef DMA_RESP_BOUNDS_EN
      acc_seen_q  <= 1'b0;
`endif
    end else begin
      if (bus.ADSTB) begin
        upper_q <= bus.DB_IN;
      end
      db_oe_q     <= rd_go_s;
      memw_seen_q <= wr_strb_s;
      if (conflict_s) begin
        err_q <= 1'b1;
      end
`ifdef DMA_RESP_BOUNDS_EN
      // One-cycle EOP pulse at the start of an out-of-window access.
      acc_seen_q <= acc_s;
      eop_n_q    <= ~(acc_s & ~acc_seen_q & ~in_win_s);
`else
      eop_n_q    <= 1'b1;
`endif
    end
  end

  assign bus.HLDA      = hlda_q;
  assign bus.DB_OE     = db_oe_q;
  assign bus.DB_OUT    = rdata_s;
  assign bus.ERR       = err_q;
  assign bus.EOP_OUT_N = eop_n_q;

endmodule

// File: doc/dma_bus_responder.md
DMA_BUS_RESPONDER -- requirements
Module: dma_bus_responder

Interface
REQ-001 Parameter MEM_AW, 8, memory index width; depth is 2**MEM_AW bytes.
REQ-002 Parameter BASE_ADDR, 16'h0000, first 16-bit address of the memory window.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 HRQ  input  1  hold request from the DMA controller.
REQ-006 HLDA  output  1  hold acknowledge to the DMA controller.
REQ-007 CPU_BUSY  input  1  high while a host CPU bus cycle is in progress.
REQ-008 AEN  input  1  DMA address enable; accesses qualify only when high.
REQ-009 ADSTB  input  1  address strobe; upper address byte is valid on DB_IN.
REQ-010 ADDR_U  input  4  address bits A7-A4.
REQ-011 ADDR_L  input  4  address bits A3-A0.
REQ-012 MEMR_N  input  1  active-low memory read strobe.
REQ-013 MEMW_N  input  1  active-low memory write strobe.
REQ-014 DB_IN  input  8  data bus sampled value.
REQ-015 DB_OUT  output  8  read data.
REQ-016 DB_OE  output  1  DB_OUT drive enable.
REQ-017 EOP_OUT_N  output  1  open-drain-style end-of-process pull; 1 = released.
REQ-018 ERR  output  1  sticky protocol error flag.

Function
REQ-019 Hold FSM states SHALL be IDLE, WAIT_CPU, GRANT, RELEASE.
REQ-020 IDLE: HRQ=1 and CPU_BUSY=0 -> GRANT; HRQ=1 and CPU_BUSY=1 -> WAIT_CPU.
REQ-021 WAIT_CPU: CPU_BUSY=0 -> GRANT; HRQ=0 -> IDLE with no grant.
REQ-022 HLDA SHALL be high exactly while the state is GRANT, i.e. one cycle after the qualifying HRQ sample.
REQ-023 GRANT: HRQ=0 -> RELEASE; RELEASE unconditionally -> IDLE; HLDA low in RELEASE.
REQ-024 Upper address byte register SHALL load DB_IN on every cycle ADSTB=1 and hold otherwise.
REQ-025 Effective address SHALL be {upper byte, ADDR_U, ADDR_L}; memory index = address - BASE_ADDR, low MEM_AW bits.
REQ-026 An access qualifies only when HLDA=1 and AEN=1; unqualified strobes SHALL have no effect.
REQ-027 Read: qualified MEMR_N=0 sampled -> next cycle DB_OE=1 and DB_OUT=mem[index]; DB_OE drops the cycle after MEMR_N=1 is sampled.
REQ-028 Write: exactly one write per strobe, committed on the first cycle a qualified MEMW_N=0 is sampled (falling-edge detect); held-low cycles SHALL NOT rewrite.
REQ-029 MEMR_N=0 and MEMW_N=0 simultaneously and qualified: no write, DB_OE=0, ERR set.
REQ-030 Memory contents SHALL NOT be initialised by RESET.

Reset
REQ-031 RESET SHALL force state IDLE, HLDA=0, DB_OE=0, DB_OUT=8'h00, EOP_OUT_N=1, ERR=0, upper byte=8'h00, strobe-edge history=released.
REQ-032 RESET during GRANT SHALL drop HLDA the following cycle and abort any pending read drive; no write commits in the reset cycle.

Configuration
REQ-033 Macro DMA_RESP_BOUNDS_EN: when defined, a qualified access with address outside [BASE_ADDR, BASE_ADDR+2**MEM_AW-1] SHALL be suppressed and EOP_OUT_N low for exactly one cycle.
REQ-034 Without DMA_RESP_BOUNDS_EN, out-of-window addresses SHALL wrap modulo 2**MEM_AW and EOP_OUT_N SHALL stay 1.

Structure
REQ-035 Package dma_pkg SHALL hold the hold-FSM state enum and the default MEM_AW/BASE_ADDR constants.
REQ-036 Storage SHALL be one sub-module dma_resp_mem (synchronous write, registered read, 8-bit data).

Verification
REQ-037 HRQ=1, CPU_BUSY=0 -> HLDA=1 next cycle; HRQ=0 -> HLDA=0 next cycle, IDLE after RELEASE.
REQ-038 HRQ=1 with CPU_BUSY=1 for 5 cycles -> HLDA=0 throughout, HLDA=1 one cycle after CPU_BUSY falls.
REQ-039 Granted, ADSTB with DB_IN=8'h00, ADDR=4'h3/4'hC, MEMW_N low 4 cycles with DB_IN=8'hA5 then MEMR_N low -> DB_OUT=8'hA5, DB_OE=1; one write observed.
REQ-040 MEMR_N and MEMW_N low together while granted -> ERR=1 and memory byte unchanged; RESET clears ERR.
REQ-041 With DMA_RESP_BOUNDS_EN, BASE_ADDR=16'h0100, access at 16'h0000 -> EOP_OUT_N low one cycle, no write; without macro, same access writes index 8'h00.
REQ-042 RESET asserted in GRANT with MEMR_N low -> HLDA=0 and DB_OE=0 next cycle.
